// File: rtl/dmem_mmio_bridge_pkg.sv
// rtl/dmem_mmio_bridge_pkg.sv - shared MMIO offsets, region select and TX_STATUS layout
package dmem_mmio_bridge_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

  localparam logic [5:0] OFF_GPIO_OUT  = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN   = 6'h04;
  localparam logic [5:0] OFF_TIME_LO   = 6'h08;
  localparam logic [5:0] OFF_TIME_HI   = 6'h0c;
  localparam logic [5:0] OFF_TX_DATA   = 6'h10;
  localparam logic [5:0] OFF_TX_STATUS = 6'h14;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/dmem_mmio_bridge_fifo.sv
// rtl/dmem_mmio_bridge_fifo.sv - registered-output synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - splits the CPU data port between BRAM and GPIO/timer/TX-FIFO registers
module dmem_mmio_bridge
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int          RAM_ADDR_W = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          GPIO_W     = 8,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            data_mem_we_i,
  input  logic [31:0]           data_mem_address_i,
  input  logic [31:0]           data_mem_write_i,
  output logic [31:0]           data_mem_read_o,
  output logic [3:0]            ram_we_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  input  logic [GPIO_W-1:0]     gpio_in_i,
  output logic [GPIO_W-1:0]     gpio_out_o,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic                  bus_err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_t          region_c, region_q;
  logic [5:0]       off;
  logic             any_we, is_mmio, wr_time, push, pop, clr_ovf, ovf_set;
  logic             fifo_full, fifo_empty, overflow;
  logic [CNT_W-1:0] fifo_count;
  logic [GPIO_W-1:0] gpio_mask, gpio_sync1, gpio_sync2;
  logic [63:0]      timer;
  logic [31:0]      mmio_rdata, mmio_q, tx_status;

  always_comb begin
    region_c = REG_NONE;
    if (data_mem_address_i[31:RAM_ADDR_W+2] == '0)
      region_c = REG_RAM;
    else if (data_mem_address_i[31:6] == MMIO_BASE[31:6])
      region_c = REG_MMIO;
  end

  // Word offset inside the MMIO window; the byte-lane bits are masked off.
  assign off     = data_mem_address_i[5:0] & 6'h3c;
  assign any_we  = |data_mem_we_i;
  assign is_mmio = (region_c == REG_MMIO);
  assign wr_time = is_mmio && (off == OFF_TIME_LO || off == OFF_TIME_HI) && any_we;
  assign push    = is_mmio && (off == OFF_TX_DATA) && data_mem_we_i[0];
  assign clr_ovf = is_mmio && (off == OFF_TX_STATUS) && data_mem_we_i[0]
                   && data_mem_write_i[STAT_OVF];
  assign pop     = tx_valid_o & tx_ready_i;
  assign ovf_set = push & fifo_full & ~pop;

  assign ram_addr_o  = data_mem_address_i[RAM_ADDR_W+1:2];
  assign ram_wdata_o = data_mem_write_i;
  assign ram_we_o    = (region_c == REG_RAM) ? data_mem_we_i : 4'b0000;

  for (genvar g = 0; g < GPIO_W; g++) begin : g_gpio_lane
    assign gpio_mask[g] = data_mem_we_i[g/8];
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(data_mem_write_i[7:0]),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (tx_data_o)
  );

  assign tx_valid_o = ~fifo_empty;

  always_comb begin
    tx_status                       = '0;
    tx_status[STAT_FULL]            = fifo_full;
    tx_status[STAT_EMPTY]           = fifo_empty;
    tx_status[STAT_OVF]             = overflow;
    tx_status[STAT_CNT_LSB +: 4]    = 4'(fifo_count);
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_GPIO_OUT:  mmio_rdata = 32'(gpio_out_o);
      OFF_GPIO_IN:   mmio_rdata = 32'(gpio_sync2);
      OFF_TIME_LO:   mmio_rdata = timer[31:0];
      OFF_TIME_HI:   mmio_rdata = timer[63:32];
      OFF_TX_STATUS: mmio_rdata = tx_status;
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      region_q   <= REG_NONE;
      mmio_q     <= '0;
      gpio_out_o <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
      timer      <= '0;
      overflow   <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      region_q   <= region_c;
      mmio_q     <= mmio_rdata;
      gpio_sync1 <= gpio_in_i;
      gpio_sync2 <= gpio_sync1;
      timer      <= wr_time ? 64'd0 : timer + 64'd1;
      bus_err_o  <= (region_c == REG_NONE) && any_we;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (is_mmio && off == OFF_GPIO_OUT)
        gpio_out_o <= (gpio_out_o & ~gpio_mask) | (data_mem_write_i[GPIO_W-1:0] & gpio_mask);
    end
  end

  // Read data follows the BRAM's one-cycle latency using the registered region.
  always_comb begin
    data_mem_read_o = '0;
    case (region_q)
      REG_RAM:  data_mem_read_o = ram_rdata_i;
      REG_MMIO: data_mem_read_o = mmio_q;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb/tb_dmem_mmio_bridge.sv - randomized bench for dmem_mmio_bridge against a transaction-level model
module tb_dmem_mmio_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data_mem_we_i = '0;
  logic [31:0] data_mem_address_i = '0;
  logic [31:0] data_mem_write_i = '0;
  logic [31:0] data_mem_read_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic [7:0]  gpio_in_i = '0;
  logic [7:0]  gpio_out_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        bus_err_o;

  dmem_mmio_bridge dut (
    .clk               (clk),
    .reset             (reset),
    .data_mem_we_i     (data_mem_we_i),
    .data_mem_address_i(data_mem_address_i),
    .data_mem_write_i  (data_mem_write_i),
    .data_mem_read_o   (data_mem_read_o),
    .ram_we_o          (ram_we_o),
    .ram_addr_o        (ram_addr_o),
    .ram_wdata_o       (ram_wdata_o),
    .ram_rdata_i       (ram_rdata_i),
    .gpio_in_i         (gpio_in_i),
    .gpio_out_o        (gpio_out_o),
    .tx_valid_o        (tx_valid_o),
    .tx_data_o         (tx_data_o),
    .tx_ready_i        (tx_ready_i),
    .bus_err_o         (bus_err_o)
  );

  always #5 clk = ~clk;

  // Environment BRAM: synchronous read-before-write.
  logic [31:0] bram [1024];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we_o[b]) bram[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    ram_rdata_i <= bram[ram_addr_o];
  end

  int checks = 0;
  int failures = 0;
  logic armed = 1'b0;

  // Reference model state, as seen during the current cycle.
  logic [31:0] ram_model [1024];
  logic [7:0]  gpio_m, s1_m, s2_m;
  logic [63:0] timer_m;
  logic        ovf_m;
  logic [7:0]  q[$];
  logic [31:0] exp_rd;
  logic        exp_err;
  logic        rdy_cur = 1'b0;
  logic [7:0]  gin_cur = '0;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] IDLE = 32'h3000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic [7:0] gin, input logic rst);
    logic        is_ram, is_mmio, pop;
    logic [5:0]  off;
    logic [31:0] rv;
    int          n;
    @(negedge clk);
    if (armed) begin
      check("read_data", data_mem_read_o, exp_rd);
      check("gpio_out", gpio_out_o, gpio_m);
      check("tx_valid", tx_valid_o, q.size() != 0);
      if (q.size() != 0) check("tx_data", tx_data_o, q[0]);
      check("bus_err", bus_err_o, exp_err);
    end
    reset = rst; data_mem_we_i = we; data_mem_address_i = a; data_mem_write_i = wd;
    tx_ready_i = rdy; gpio_in_i = gin;
    #1;
    is_ram  = (a < 32'h0000_1000);
    is_mmio = ((a >> 6) == (BASE >> 6));
    off     = a[5:0] & 6'h3c;
    check("ram_we", ram_we_o, is_ram ? we : 4'b0000);
    check("ram_addr", ram_addr_o, a[11:2]);
    if (rst) begin
      gpio_m = '0; s1_m = '0; s2_m = '0; timer_m = '0; ovf_m = 1'b0;
      q.delete(); exp_rd = '0; exp_err = 1'b0; armed = 1'b1;
      return;
    end
    n  = q.size();
    rv = '0;
    if (is_ram) rv = ram_model[a[11:2]];
    else if (is_mmio)
      case (off)
        6'h00: rv = {24'b0, gpio_m};
        6'h04: rv = {24'b0, s2_m};
        6'h08: rv = timer_m[31:0];
        6'h0c: rv = timer_m[63:32];
        6'h14: rv = {24'b0, 4'(n), 1'b0, ovf_m, n == 0, n == 4};
        default: rv = '0;
      endcase
    exp_rd  = rv;
    exp_err = !is_ram && !is_mmio && (we != 0);
    pop = (n != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (is_mmio && off == 6'h10 && we[0]) begin
      if (q.size() < 4) q.push_back(wd[7:0]);
      else ovf_m = 1'b1;
    end
    if (is_mmio && off == 6'h14 && we[0] && wd[2]) ovf_m = 1'b0;
    if (is_mmio && off == 6'h00 && we[0]) gpio_m = wd[7:0];
    timer_m = (is_mmio && (off == 6'h08 || off == 6'h0c) && we != 0) ? 64'd0 : timer_m + 64'd1;
    s2_m = s1_m;
    s1_m = gin;
    if (is_ram)
      for (int b = 0; b < 4; b++)
        if (we[b]) ram_model[a[11:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    cycle(we, a, wd, rdy_cur, gin_cur, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(4'b0000, a, 32'h0, rdy_cur, gin_cur, 1'b0);
  endtask

  task automatic rst_cycle();
    cycle(4'b0000, IDLE, 32'h0, rdy_cur, gin_cur, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic [9:0]  word;
    int          idx;

    rst_cycle();
    rst_cycle();

    // Preload the RAM words the random phase uses so the model knows their contents.
    for (int w = 0; w < 16; w++) begin
      word = (w < 8) ? 10'(w) : 10'(1008 + w);
      wr({20'b0, word, 2'b00}, $urandom, 4'b1111);
    end

    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h0000_0010);
    rd(IDLE);

    wr(BASE + 32'h00, 32'h0000_00A5, 4'b0001);
    rd(BASE + 32'h00);
    gin_cur = 8'h3C;
    for (int i = 0; i < 4; i++) rd(BASE + 32'h04);

    wr(BASE + 32'h08, $urandom, 4'b0100);
    for (int i = 0; i < 3; i++) rd(IDLE);
    rd(BASE + 32'h08);
    for (int i = 0; i < 4; i++) rd(IDLE);
    rd(BASE + 32'h08);
    rd(BASE + 32'h0c);

    rdy_cur = 1'b0;
    wr(BASE + 32'h10, 32'h11, 4'b0001);
    wr(BASE + 32'h10, 32'h22, 4'b0001);
    wr(BASE + 32'h10, 32'h33, 4'b0001);
    wr(BASE + 32'h10, 32'h44, 4'b0001);
    wr(BASE + 32'h10, 32'h55, 4'b0001);
    rd(BASE + 32'h14);
    rd(BASE + 32'h10);
    rdy_cur = 1'b1;
    for (int i = 0; i < 5; i++) rd(BASE + 32'h14);

    rdy_cur = 1'b0;
    for (int i = 0; i < 4; i++) wr(BASE + 32'h10, 32'hA0 + i, 4'b0001);
    wr(BASE + 32'h10, 32'hEE, 4'b0001);
    rdy_cur = 1'b1;
    wr(BASE + 32'h10, 32'h66, 4'b0001);
    rdy_cur = 1'b0;
    rd(BASE + 32'h14);
    wr(BASE + 32'h14, 32'h4, 4'b0001);
    rd(BASE + 32'h14);
    rd(IDLE);

    wr(32'h2000_0000, 32'h1234_5678, 4'b1111);
    rd(IDLE);
    rd(IDLE);
    wr(32'h0000_1000, 32'h0, 4'b0010);
    wr(BASE + 32'h40, 32'h0, 4'b1000);
    wr(BASE + 32'h3c, 32'h0, 4'b1111);
    rd(IDLE);

    wr(BASE + 32'h00, 32'h5A, 4'b0001);
    rd(32'h0000_0010);
    rst_cycle();
    rd(IDLE);
    rd(IDLE);

    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          idx  = $urandom_range(0, 15);
          word = (idx < 8) ? 10'(idx) : 10'(1008 + idx);
          a    = {20'b0, word, 2'($urandom)};
        end
        3:       a = BASE + 32'h10;
        4:       a = BASE + 32'h14;
        5, 6:    a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        7: begin
          case ($urandom_range(0, 3))
            0:       a = 32'h0000_1000;
            1:       a = BASE + 32'h40;
            2:       a = 32'h2000_0000;
            default: a = 32'h0FFF_FFFC;
          endcase
        end
        8:       a = BASE + 32'h08 + 32'($urandom_range(0, 1) * 4);
        default: a = $urandom;
      endcase
      rdy_cur = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) gin_cur = 8'($urandom);
      if ($urandom_range(0, 499) == 0)
        rst_cycle();
      else
        cycle(($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000, a, $urandom,
              rdy_cur, gin_cur, 1'b0);
    end
    rd(IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
